// File: rtl/adam_aes_key_schedule_iter.sv
// adam_aes_key_schedule_iter: iterative AES-128 key expansion, one round key per cycle, full schedule held in registers.
// Ports: clk, reset (sync, active-high), init (start, sampled when ready), keylen (0=AES-128, 1=AES-256 rejected),
//   key[255:0] (AES-128 key in [255:128]), ready (idle), valid (schedule complete), err (reject pulse),
//   round_keys[0:NUM_ROUNDS] (round_keys[0] = cipher key).
// Optional macro ADAM_AES_KEY_CACHE_EN: skip re-expansion when the same key is re-initialised while valid.
module adam_aes_key_schedule_iter #(
    parameter int         NUM_ROUNDS = 10,
    parameter logic [7:0] RCON_INIT  = 8'h01
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic         keylen,
    input  logic [255:0] key,
    output logic         ready,
    output logic         valid,
    output logic         err,
    output logic [127:0] round_keys [0:NUM_ROUNDS]
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    generate
        if (NUM_ROUNDS != 10) begin : g_bad_rounds
            $error("adam_aes_key_schedule_iter supports only NUM_ROUNDS = 10");
        end
    endgenerate
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? {a[6:0], 1'b0} ^ 8'h1b : {a[6:0], 1'b0};
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction
    // S-box as GF(2^8) inverse (a^254, which maps 0 to 0) followed by the AES affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction
    logic [1:0]   state;
    logic [3:0]   cnt;
    logic [7:0]   rcon;
    logic [127:0] prev;
    logic [31:0]  rot;
    logic [31:0]  sub;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [31:0]  w2;
    logic [31:0]  w3;
    logic         hit;
    logic         unused_key_lo;
    assign unused_key_lo = ^key[127:0];
    assign ready = state == IDLE;
    assign prev  = round_keys[cnt - 4'd1];
    assign rot   = {prev[23:0], prev[31:24]};
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            assign sub[8*g +: 8] = sbox(rot[8*g +: 8]);
        end
    endgenerate
    assign w0 = prev[127:96] ^ sub ^ {rcon, 24'h0};
    assign w1 = prev[95:64] ^ w0;
    assign w2 = prev[63:32] ^ w1;
    assign w3 = prev[31:0] ^ w2;
`ifdef ADAM_AES_KEY_CACHE_EN
    logic [127:0] cached_key;
    assign hit = valid && key[255:128] == cached_key;
    always_ff @(posedge clk) begin
        if (reset) cached_key <= '0;
        else if (state == DONE) cached_key <= round_keys[0];
    end
`else
    assign hit = 1'b0;
`endif
    always_ff @(posedge clk) begin
        err <= 1'b0;
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rcon  <= RCON_INIT;
            valid <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) round_keys[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (init && keylen) err <= 1'b1;
                    else if (init && !hit) begin
                        round_keys[0] <= key[255:128];
                        valid         <= 1'b0;
                        cnt           <= 4'd1;
                        rcon          <= RCON_INIT;
                        state         <= EXPAND;
                    end
                end
                EXPAND: begin
                    round_keys[cnt] <= {w0, w1, w2, w3};
                    rcon            <= xtime(rcon);
                    cnt             <= cnt + 4'd1;
                    if (cnt == 4'(NUM_ROUNDS)) state <= DONE;
                end
                DONE: begin
                    valid <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adam_aes_key_schedule_iter.sv
// tb_adam_aes_key_schedule_iter: directed FIPS-197 vectors for the iterative AES-128 key schedule.
module tb_adam_aes_key_schedule_iter;
    localparam logic [127:0] KA    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KA_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KA_2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] KA_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KB    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KB_1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KB_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
`ifdef ADAM_AES_KEY_CACHE_EN
    localparam int SAME_LAT = 0;
`else
    localparam int SAME_LAT = 11;
`endif
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         init = 1'b0;
    logic         keylen = 1'b0;
    logic [255:0] key = '0;
    logic         ready;
    logic         valid;
    logic         err;
    logic [127:0] rk [0:10];
    int           total = 0;
    int           fails = 0;
    int           low;
    int           nz;
    logic         err_seen;
    logic         valid_drop;
    adam_aes_key_schedule_iter dut (
        .clk(clk), .reset(reset), .init(init), .keylen(keylen), .key(key),
        .ready(ready), .valid(valid), .err(err), .round_keys(rk)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic pulse_init(input logic [127:0] k, input logic kl);
        key    = {k, 128'h0};
        keylen = kl;
        init   = 1'b1;
        @(negedge clk);
        init   = 1'b0;
    endtask
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask
    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_valid", valid, 0);
        check("rst_err", err, 0);
        check("rst_rk0", rk[0], 0);
        check("rst_rk10", rk[10], 0);
        pulse_init(KA, 1'b0);
        check("a_ready_low", ready, 0);
        check("a_valid_low", valid, 0);
        wait_ready(low);
        check("a_latency", low, 11);
        check("a_valid", valid, 1);
        check("a_rk0", rk[0], KA);
        check("a_rk1", rk[1], KA_1);
        check("a_rk2", rk[2], KA_2);
        check("a_rk10", rk[10], KA_10);
        key      = {KB, 128'h0};
        init     = 1'b1;
        err_seen = 1'b0;
        @(negedge clk);
        low = 0;
        while (!ready && low < 40) begin
            low++;
            init = (low == 3 || low == 7);
            @(negedge clk);
            if (err) err_seen = 1'b1;
        end
        init = 1'b0;
        check("b_latency_ignore_init", low, 11);
        check("b_no_err", err_seen, 0);
        check("b_rk1", rk[1], KB_1);
        check("b_rk10", rk[10], KB_10);
        check("b_valid", valid, 1);
        pulse_init(KA, 1'b1);
        check("len_err_pulse", err, 1);
        check("len_ready", ready, 1);
        check("len_valid", valid, 1);
        @(negedge clk);
        check("len_err_drop", err, 0);
        check("len_rk0", rk[0], KB);
        check("len_rk10", rk[10], KB_10);
        pulse_init(KA, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_valid", valid, 0);
        nz = 0;
        for (int i = 0; i <= 10; i++) if (rk[i] !== '0) nz++;
        check("mid_rst_rk_zero", nz, 0);
        @(negedge clk);
        pulse_init(KA, 1'b0);
        wait_ready(low);
        check("fresh_latency", low, 11);
        check("fresh_rk10", rk[10], KA_10);
        pulse_init(KB, 1'b0);
        wait_ready(low);
        check("b2b_first_latency", low, 11);
        check("b2b_first_valid", valid, 1);
        pulse_init(KA, 1'b0);
        check("b2b_valid_drop", valid, 0);
        check("b2b_ready_drop", ready, 0);
        wait_ready(low);
        check("b2b_second_latency", low, 11);
        check("b2b_rk0", rk[0], KA);
        check("b2b_rk10", rk[10], KA_10);
        valid_drop = 1'b0;
        key  = {KA, 128'h0};
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        low = 0;
        while (!ready && low < 40) begin
            if (!valid) valid_drop = 1'b1;
            low++;
            @(negedge clk);
        end
        check("same_latency", low, SAME_LAT);
        check("same_valid_drop", valid_drop, SAME_LAT != 0);
        check("same_rk10", rk[10], KA_10);
        check("same_valid", valid, 1);
        pulse_init(KB, 1'b0);
        wait_ready(low);
        check("diff_latency", low, 11);
        check("diff_rk10", rk[10], KB_10);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
